matmul_ctrl: RTL and testbench
==============================

# matmul_ctrl

Sequencer for the 32×8 multi-read-port register file in the 2×2 matrix-multiply datapath.
- Streams in two 2×2 unsigned 8-bit matrices A and B and writes them into the register file.
- Computes C = A·B using all four read ports: one C element per two cycles.
- Writes C back to the register file, then streams C out.
- Sits between the host-side byte streams and the register file; it is the only master of the file's write port and read ports during a job.

## Interface
Parameters:
- A_BASE, 5'd0, register-file base address of A (row-major, 4 entries)
- B_BASE, 5'd4, base address of B (row-major, 4 entries)
- C_BASE, 5'd8, base address of C (row-major, 4 entries)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a job; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last C byte is accepted
- ovf  out  1  sticky; an element sum exceeded 255 in the current/last job
- in_valid  in  1  input byte valid
- in_ready  out  1  controller accepts input byte
- in_data  in  8  A[0..3] then B[0..3]
- out_valid  out  1  output byte valid
- out_ready  in  1  sink accepts output byte
- out_data  out  8  C[0..3]
- rf_write  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  8  write data
- rf_raddr1..rf_raddr4  out  5 each  read addresses
- rf_rdata1..rf_rdata4  in  8 each  combinational read data

## Operation
- **IDLE**
  - in_ready=0, out_valid=0.
  - start=1 → LOAD; clear the load counter and ovf.
- **LOAD**
  - in_ready=1.
  - Each in_valid&&in_ready beat k (0..7) drives rf_write=1 and rf_wdata=in_data in the same cycle.
  - rf_waddr is A_BASE+k for k<4, else B_BASE+(k-4).
  - After beat 7 → CALC with idx=0.
- **CALC** (idx = 2·i + j)
  - Read addresses: rf_raddr1=A_BASE+2i, rf_raddr2=A_BASE+2i+1, rf_raddr3=B_BASE+j, rf_raddr4=B_BASE+2+j.
  - Register the 17-bit sum rdata1·rdata3 + rdata2·rdata4, using 16-bit unsigned products.
  - If sum>255, set ovf.
  - → WRITE.
- **WRITE**
  - rf_write=1, rf_waddr=C_BASE+idx, rf_wdata = the result byte (see Configuration).
  - idx==3 → DRAIN with idx=0; otherwise increment idx → CALC.
- **DRAIN**
  - rf_raddr1=C_BASE+idx, out_valid=1, out_data=rf_rdata1.
  - On out_valid&&out_ready: increment idx.
  - At idx==3 accepted: pulse done and go to IDLE.
- Address arithmetic is modulo 32. Overlapping A/B/C regions are an integration error and are not checked.
- start while busy is ignored. in_valid outside LOAD is ignored and not consumed.
- When not writing, rf_write=0 and rf_waddr/rf_wdata=0. When not in CALC/DRAIN, all rf_raddr=0.

## Timing
- Reset values: busy=0, done=0, ovf=0, in_ready=0, out_valid=0, out_data=0, rf_write=0, all addresses and wdata=0. State=IDLE, counters=0.
- Reset mid-job aborts to IDLE on the next edge. Register-file contents are not touched by the controller.
- start sampled at edge N → in_ready=1 from cycle N+1.
- LOAD takes at least 8 cycles; stalls on in_valid=0.
- CALC+WRITE takes exactly 2 cycles per element, 8 cycles total, with no backpressure.
- DRAIN takes at least 4 cycles. out_data holds stable while out_valid&&!out_ready.
- Minimum start-to-done is 1+8+8+4 = 21 cycles. done asserts in the cycle after the final accepted beat, together with busy=0.
- A new start is accepted in the cycle done is high.
- ovf is cleared only by an accepted start or by reset.

## Configuration
- SATURATE_EN defined: the written C byte is 8'd255 when sum>255, else sum[7:0].
- SATURATE_EN undefined: the written C byte is sum[7:0] (truncation).
- ovf behaves identically in both builds.

## Test plan
- A=1,2,3,4, B=5,6,7,8, no stalls → file[8..11]=19,22,43,50; out_data sequence 19,22,43,50; done at cycle 21; ovf=0.
- All A, B bytes =200 → sum=80000; out_data=128 ×4 without SATURATE_EN, 255 ×4 with; ovf=1 after the first CALC.
- in_valid toggled 1/0 each cycle during LOAD, out_ready held low 3 cycles on C[1] → values unchanged from the first case; out_data=22 stable while stalled.
- start pulsed during CALC and again in the done cycle → first ignored; second begins a new job with ovf cleared.
- rst_n low for 1 cycle during DRAIN → next cycle all outputs at reset values, busy=0; a fresh job completes correctly.
- A_BASE=20, B_BASE=28, C_BASE=30, identity A, B=9,8,7,6 → writes go to 20–23, 28–31 and 30,31,0,1 (wraps mod 32), which overlaps B; the bench checks only the address sequence.

Source files
------------

// File: rtl/matmul_ctrl_if.sv
// Host byte streams plus register-file ports of the 2x2 matmul sequencer.
// master = controller side; slave = host streams and register file.
interface matmul_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       rf_write;
    logic [4:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [4:0] rf_raddr1;
    logic [4:0] rf_raddr2;
    logic [4:0] rf_raddr3;
    logic [4:0] rf_raddr4;
    logic [7:0] rf_rdata1;
    logic [7:0] rf_rdata2;
    logic [7:0] rf_rdata3;
    logic [7:0] rf_rdata4;

    modport master (
        input  in_valid, in_data, out_ready,
        input  rf_rdata1, rf_rdata2, rf_rdata3, rf_rdata4,
        output in_ready, out_valid, out_data,
        output rf_write, rf_waddr, rf_wdata,
        output rf_raddr1, rf_raddr2, rf_raddr3, rf_raddr4
    );

    modport slave (
        output in_valid, in_data, out_ready,
        output rf_rdata1, rf_rdata2, rf_rdata3, rf_rdata4,
        input  in_ready, out_valid, out_data,
        input  rf_write, rf_waddr, rf_wdata,
        input  rf_raddr1, rf_raddr2, rf_raddr3, rf_raddr4
    );
endinterface

// File: rtl/matmul_ctrl.sv
// Sequencer for a 2x2 8-bit matrix multiply over a 32x8 four-read-port register file.
// Define SATURATE_EN to clamp overflowing C bytes to 255 instead of truncating them.
module matmul_ctrl #(
    parameter logic [4:0] A_BASE = 5'd0,
    parameter logic [4:0] B_BASE = 5'd4,
    parameter logic [4:0] C_BASE = 5'd8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    matmul_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;      // load beat k in LOAD, element idx elsewhere
    logic [16:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [4:0]  idx_off;
    logic [15:0] prod_lo, prod_hi;
    logic [7:0]  result;

    assign idx_off = {3'b000, cnt_q[1:0]};
    assign prod_lo = {8'd0, bus.rf_rdata1} * {8'd0, bus.rf_rdata3};
    assign prod_hi = {8'd0, bus.rf_rdata2} * {8'd0, bus.rf_rdata4};

`ifdef SATURATE_EN
    assign result = (sum_q > 17'd255) ? 8'hff : sum_q[7:0];
`else
    logic [8:0] unused_sum_hi;
    assign unused_sum_hi = sum_q[16:8];
    assign result        = sum_q[7:0];
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        ovf_d         = ovf_q;
        done_d        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'd0;
        bus.rf_write  = 1'b0;
        bus.rf_waddr  = 5'd0;
        bus.rf_wdata  = 8'd0;
        bus.rf_raddr1 = 5'd0;
        bus.rf_raddr2 = 5'd0;
        bus.rf_raddr3 = 5'd0;
        bus.rf_raddr4 = 5'd0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = 3'd0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.rf_write = 1'b1;
                    bus.rf_wdata = bus.in_data;
                    bus.rf_waddr = (cnt_q[2] ? B_BASE : A_BASE) + idx_off;
                    cnt_d        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = S_CALC;
                end
            end
            S_CALC: begin
                // idx = 2*i + j: row i of A against column j of B
                bus.rf_raddr1 = A_BASE + {3'b000, cnt_q[1], 1'b0};
                bus.rf_raddr2 = A_BASE + {3'b000, cnt_q[1], 1'b1};
                bus.rf_raddr3 = B_BASE + {4'b0000, cnt_q[0]};
                bus.rf_raddr4 = B_BASE + 5'd2 + {4'b0000, cnt_q[0]};
                sum_d         = {1'b0, prod_lo} + {1'b0, prod_hi};
                if (sum_d > 17'd255) ovf_d = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                bus.rf_write = 1'b1;
                bus.rf_waddr = C_BASE + idx_off;
                bus.rf_wdata = result;
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = S_DRAIN;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = S_CALC;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            S_DRAIN: begin
                bus.rf_raddr1 = C_BASE + idx_off;
                bus.out_valid = 1'b1;
                bus.out_data  = bus.rf_rdata1;
                if (bus.out_ready) begin
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            sum_q   <= 17'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: job-level matrix model, per-cycle bus monitor,
// plus a second instance with relocated bases for address wrap checks.
`timescale 1ns/1ps
module tb_matmul_ctrl;
    typedef logic [3:0][7:0] mat_t;
    typedef struct packed { logic [4:0] addr; logic [7:0] data; } wr_t;
    typedef struct {
        int         lat;
        logic       ovf_c1;
        logic       ovf_c10;
        int         stalls;
        logic [7:0] stall_val;
        bit         aborted;
    } obs_t;

    localparam logic [4:0] A0 = 5'd0, B0 = 5'd4, C0 = 5'd8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy0, done0, ovf0, busy1, done1, ovf1;

    matmul_ctrl_if bus0 ();
    matmul_ctrl_if bus1 ();

    matmul_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy0), .done(done0), .ovf(ovf0), .bus(bus0)
    );

    matmul_ctrl #(.A_BASE(5'd20), .B_BASE(5'd28), .C_BASE(5'd30)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy1), .done(done1), .ovf(ovf1), .bus(bus1)
    );

    always #5 clk = ~clk;

    logic [7:0] rf0 [32];
    logic [7:0] rf1 [32];

    assign bus0.rf_rdata1 = rf0[bus0.rf_raddr1];
    assign bus0.rf_rdata2 = rf0[bus0.rf_raddr2];
    assign bus0.rf_rdata3 = rf0[bus0.rf_raddr3];
    assign bus0.rf_rdata4 = rf0[bus0.rf_raddr4];
    assign bus1.rf_rdata1 = rf1[bus1.rf_raddr1];
    assign bus1.rf_rdata2 = rf1[bus1.rf_raddr2];
    assign bus1.rf_rdata3 = rf1[bus1.rf_raddr3];
    assign bus1.rf_rdata4 = rf1[bus1.rf_raddr4];
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_data   = bus0.in_data;
    assign bus1.out_ready = bus0.out_ready;

    always @(posedge clk) begin
        if (bus0.rf_write) rf0[bus0.rf_waddr] <= bus0.rf_wdata;
        if (bus1.rf_write) rf1[bus1.rf_waddr] <= bus1.rf_wdata;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    wr_t        wq[$];
    logic [7:0] oq[$];
    logic [4:0] addr1_q[$];
    bit         collect1 = 1'b0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'd0;
    wr_t        mon_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // C = A*B with row-major 2x2 matrices, result byte per the build's overflow rule
    function automatic void ref_mul(input mat_t a, input mat_t b, output mat_t c, output logic ov);
        int s;
        ov = 1'b0;
        c  = '0;
        for (int e = 0; e < 4; e++) begin
            s = int'(a[(e / 2) * 2]) * int'(b[e % 2]) + int'(a[(e / 2) * 2 + 1]) * int'(b[2 + e % 2]);
            if (s > 255) ov = 1'b1;
`ifdef SATURATE_EN
            c[e] = (s > 255) ? 8'd255 : s[7:0];
`else
            c[e] = s[7:0];
`endif
        end
    endfunction

    // Per-cycle compare of DUT0 write port and output stream against the expected queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.rf_write) begin
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_write: got addr %0d, expected no write", bus0.rf_waddr);
                end else begin
                    mon_w = wq.pop_front();
                    check("rf_waddr", 32'(bus0.rf_waddr), 32'(mon_w.addr));
                    check("rf_wdata", 32'(bus0.rf_wdata), 32'(mon_w.data));
                end
            end else begin
                check("rf_idle_bus", 32'({bus0.rf_waddr, bus0.rf_wdata}), 32'd0);
            end
            if (bus0.out_valid) begin
                if (hold_v) check("out_hold", 32'(bus0.out_data), 32'(hold_d));
                if (bus0.out_ready) begin
                    if (oq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_out: got %0d, expected no beat", bus0.out_data);
                    end else begin
                        check("out_data", 32'(bus0.out_data), 32'(oq.pop_front()));
                    end
                    hold_v <= 1'b0;
                end else begin
                    hold_v <= 1'b1;
                    hold_d <= bus0.out_data;
                end
            end else begin
                hold_v <= 1'b0;
            end
            if (done0) check("done_not_busy", 32'(busy0), 32'd0);
            if (collect1 && bus1.rf_write) addr1_q.push_back(bus1.rf_waddr);
        end else begin
            hold_v <= 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_ovf"}, 32'(ovf0), 32'd0);
        check({tag, "_in_ready"}, 32'(bus0.in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus0.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(bus0.out_data), 32'd0);
        check({tag, "_rf_write"}, 32'(bus0.rf_write), 32'd0);
        check({tag, "_wr_bus"}, 32'({bus0.rf_waddr, bus0.rf_wdata}), 32'd0);
        check({tag, "_raddrs"},
              32'({bus0.rf_raddr1, bus0.rf_raddr2, bus0.rf_raddr3, bus0.rf_raddr4}), 32'd0);
    endtask

    // Runs one job from the current cycle; start is raised now and sampled at the next edge.
    // in_mode: 0 always valid, 1 toggle, 2 random. out_mode: 0 always ready, 1 stall C[1] 3 cycles, 2 random.
    task automatic do_job(input mat_t a, input mat_t b, input int in_mode, input int out_mode,
                          input bit poke_calc, input bit abort, output obs_t o);
        mat_t c;
        logic ov;
        int   k, nacc;
        bit   acc_in, acc_out, done_seen, poked, want;
        ref_mul(a, b, c, ov);
        for (int e = 0; e < 4; e++) wq.push_back(wr_t'{addr: A0 + 5'(e), data: a[e]});
        for (int e = 0; e < 4; e++) wq.push_back(wr_t'{addr: B0 + 5'(e), data: b[e]});
        for (int e = 0; e < 4; e++) wq.push_back(wr_t'{addr: C0 + 5'(e), data: c[e]});
        for (int e = 0; e < 4; e++) oq.push_back(c[e]);
        o.lat = 0; o.ovf_c1 = 1'bx; o.ovf_c10 = 1'bx; o.stalls = 0; o.stall_val = 8'd0; o.aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        o.lat = 1; k = 0; nacc = 0; done_seen = 1'b0; poked = 1'b0;
        while (!done_seen && o.lat < 300) begin
            if (abort && bus0.out_valid) begin
                bus0.out_ready = 1'b0;
                bus0.in_valid  = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_reset_outputs("abort");
                wq.delete();
                oq.delete();
                o.aborted = 1'b1;
                return;
            end
            want = (in_mode == 0) || (in_mode == 1 && o.lat % 2 == 1) ||
                   (in_mode == 2 && $urandom_range(0, 2) != 0);
            if (k < 8 && want) begin
                bus0.in_valid = 1'b1;
                bus0.in_data  = (k < 4) ? a[k] : b[k - 4];
            end else begin
                bus0.in_valid = (k >= 8 && in_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus0.in_data  = 8'($urandom);
            end
            bus0.out_ready = 1'b1;
            if (out_mode == 1 && bus0.out_valid && nacc == 1 && o.stalls < 3) begin
                bus0.out_ready = 1'b0;
                o.stalls++;
            end else if (out_mode == 2) begin
                bus0.out_ready = 1'($urandom_range(0, 1));
            end
            if (poke_calc && !poked && busy0 && !bus0.in_ready && !bus0.out_valid) begin
                start = 1'b1;
                poked = 1'b1;
            end
            #2;
            acc_in  = bus0.in_valid && bus0.in_ready;
            acc_out = bus0.out_valid && bus0.out_ready;
            if (out_mode == 1 && bus0.out_valid && !bus0.out_ready) o.stall_val = bus0.out_data;
            if (o.lat == 1)  o.ovf_c1  = ovf0;
            if (o.lat == 10) o.ovf_c10 = ovf0;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc_in)  k++;
            if (acc_out) nacc++;
            o.lat++;
            done_seen = done0;
        end
        bus0.in_valid = 1'b0;
        if (!done_seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL job_timeout: got no done after %0d cycles, expected done", o.lat);
        end
        check("job_ovf", 32'(ovf0), 32'(ov));
        for (int e = 0; e < 4; e++) check("rf_c", 32'(rf0[C0 + 5'(e)]), 32'(c[e]));
        check("queues_drained", wq.size() + oq.size(), 32'd0);
    endtask

    initial begin
        obs_t       o;
        mat_t       a1, b1, big, ida, idb, ra, rb;
        logic [7:0] sat_exp;
        int         exp_a1 [12];
        rst_n = 1'b0;
        start = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = 8'd0;
        bus0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("reset");

        a1  = {8'd4, 8'd3, 8'd2, 8'd1};
        b1  = {8'd8, 8'd7, 8'd6, 8'd5};
        big = {4{8'd200}};
`ifdef SATURATE_EN
        sat_exp = 8'd255;
`else
        sat_exp = 8'd128;
`endif

        // Basic job, no stalls
        do_job(a1, b1, 0, 0, 1'b0, 1'b0, o);
        check("t1_latency", o.lat, 21);
        check("t1_c0", 32'(rf0[8]), 32'd19);
        check("t1_c1", 32'(rf0[9]), 32'd22);
        check("t1_c2", 32'(rf0[10]), 32'd43);
        check("t1_c3", 32'(rf0[11]), 32'd50);
        check("t1_ovf", 32'(ovf0), 32'd0);

        // Overflowing sums
        do_job(big, big, 0, 0, 1'b0, 1'b0, o);
        check("t2_ovf_after_calc", 32'(o.ovf_c10), 32'd1);
        for (int e = 0; e < 4; e++) check("t2_c", 32'(rf0[C0 + 5'(e)]), 32'(sat_exp));

        // Input stalls and output backpressure on C[1]
        do_job(a1, b1, 1, 1, 1'b0, 1'b0, o);
        check("t3_latency", o.lat, 31);
        check("t3_stalls", o.stalls, 3);
        check("t3_stall_val", 32'(o.stall_val), 32'd22);

        // start during CALC is ignored; start in the done cycle begins the next job
        do_job(big, big, 0, 0, 1'b1, 1'b0, o);
        check("t4_latency", o.lat, 21);
        check("t4_ovf_set", 32'(ovf0), 32'd1);
        do_job(a1, b1, 0, 0, 1'b0, 1'b0, o);
        check("t4_ovf_cleared", 32'(o.ovf_c1), 32'd0);
        check("t4_latency2", o.lat, 21);

        // Reset during DRAIN, then a fresh job
        do_job(a1, b1, 0, 0, 1'b0, 1'b1, o);
        check("t5_aborted", 32'(o.aborted), 32'd1);
        do_job(big, b1, 0, 0, 1'b0, 1'b0, o);
        check("t5_latency", o.lat, 21);

        // Relocated instance: address sequence wraps modulo 32
        ida = {8'd1, 8'd0, 8'd0, 8'd1};
        idb = {8'd6, 8'd7, 8'd8, 8'd9};
        exp_a1 = '{20, 21, 22, 23, 28, 29, 30, 31, 30, 31, 0, 1};
        addr1_q.delete();
        collect1 = 1'b1;
        do_job(ida, idb, 0, 0, 1'b0, 1'b0, o);
        collect1 = 1'b0;
        check("t6_nwrites", addr1_q.size(), 32'd12);
        for (int e = 0; e < 12 && e < addr1_q.size(); e++)
            check("t6_waddr", 32'(addr1_q[e]), 32'(exp_a1[e]));
        check("t6_c0_identity", 32'(rf0[8]), 32'd9);

        // Randomized jobs with random stalls and occasional start pokes
        for (int r = 0; r < 10; r++) begin
            ra = mat_t'($urandom);
            rb = mat_t'($urandom);
            if (r % 2 == 0) begin
                ra = ra & 32'h0f0f0f0f;
                rb = rb & 32'h0f0f0f0f;
            end
            do_job(ra, rb, 2, 2, 1'($urandom_range(0, 1)), 1'b0, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
